// File: rtl/mult_div_unit.sv
// Execute-stage multi-cycle multiply/divide unit owning the HI/LO registers.
// Iterative shift-add multiply and restoring shift-subtract divide on operand
// magnitudes, with a one-cycle sign-fixup state before HI/LO are written.
// Optional feature macro: MULT_DIV_FAST_MULT_EN (single-cycle MULT/MULTU).
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic             mthi_e,
  input  logic             mtlo_e,
  input  logic             flush_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e state_q, state_d;

  logic             is_div_q;   // op_e[1] of the latched operation
  logic             sa_q;       // dividend was negative (signed op)
  logic             sd_q;       // operand signs differ (signed op)
  logic             div0_q;
  logic [WIDTH-1:0] a_q;        // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] bmag_q;
  logic [WIDTH-1:0] acc_q;      // product high half / partial remainder
  logic [WIDTH-1:0] mq_q;       // multiplier low half / dividend-quotient
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic start_go, mt_go, fix_go, iter_en;
  logic fast_go;

  // Operand sign handling at start
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = ~op_e[0] & src_a_e[WIDTH-1];
    b_neg = ~op_e[0] & src_b_e[WIDTH-1];
    a_mag = a_neg ? (~src_a_e + 1'b1) : src_a_e;
    b_mag = b_neg ? (~src_b_e + 1'b1) : src_b_e;
  end

`ifdef MULT_DIV_FAST_MULT_EN
  // Sign-extended 2*WIDTH operands give the correct low 2*WIDTH product bits
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{a_neg}}, src_a_e} * {{WIDTH{b_neg}}, src_b_e};
`endif

  // Next-state and control decode
  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    mt_go    = 1'b0;
    fix_go   = 1'b0;
    iter_en  = 1'b0;
    fast_go  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!flush_e && start_e) begin
          start_go = 1'b1;
`ifdef MULT_DIV_FAST_MULT_EN
          if (op_e[1]) state_d = StIter;
          else         fast_go = 1'b1;
`else
          state_d = StIter;
`endif
        end else if (!flush_e) begin
          mt_go = 1'b1;
        end
      end
      StIter: begin
        if (flush_e) begin
          state_d = StIdle;
        end else begin
          iter_en = 1'b1;
          if (cnt_q == LastCnt) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        fix_go  = ~flush_e;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // One iteration step for multiply and divide
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_borrow;
  logic [WIDTH-1:0] acc_nxt, mq_nxt;

  always_comb begin
    mul_sum    = {1'b0, acc_q} + (mq_q[0] ? {1'b0, bmag_q} : '0);
    div_shift  = {acc_q, mq_q[WIDTH-1]};
    div_borrow = div_shift < {1'b0, bmag_q};
    if (is_div_q) begin
      // Partial remainder stays below the divisor, so WIDTH bits hold the result
      acc_nxt = div_borrow ? div_shift[WIDTH-1:0] : (div_shift[WIDTH-1:0] - bmag_q);
      mq_nxt  = {mq_q[WIDTH-2:0], ~div_borrow};
    end else begin
      acc_nxt = mul_sum[WIDTH:1];
      mq_nxt  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end
  end

  // Sign fixup and special cases for the final write
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   hi_res, lo_res;

  always_comb begin
    prod_raw = {acc_q, mq_q};
    prod_fix = sd_q ? (~prod_raw + 1'b1) : prod_raw;
    if (!is_div_q) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (div0_q) begin
      hi_res = a_q;
      lo_res = '1;
    end else begin
      hi_res = sa_q ? (~acc_q + 1'b1) : acc_q;
      lo_res = sd_q ? (~mq_q + 1'b1) : mq_q;
    end
  end

  // Datapath, HI/LO and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sd_q     <= 1'b0;
      div0_q   <= 1'b0;
      a_q      <= '0;
      bmag_q   <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_go) begin
        is_div_q <= op_e[1];
        sa_q     <= a_neg;
        sd_q     <= a_neg ^ b_neg;
        div0_q   <= (src_b_e == '0);
        a_q      <= src_a_e;
        bmag_q   <= b_mag;
        acc_q    <= '0;
        mq_q     <= a_mag;
        cnt_q    <= '0;
      end
`ifdef MULT_DIV_FAST_MULT_EN
      if (fast_go) begin
        hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
        lo_q   <= fast_prod[WIDTH-1:0];
        done_q <= 1'b1;
      end
`endif
      if (mt_go) begin
        if (mthi_e) hi_q <= src_a_e;
        if (mtlo_e) lo_q <= src_a_e;
      end
      if (iter_en) begin
        acc_q <= acc_nxt;
        mq_q  <= mq_nxt;
        cnt_q <= cnt_q + CW'(1);
      end
      if (fix_go) begin
        hi_q   <= hi_res;
        lo_q   <= lo_res;
        done_q <= 1'b1;
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (default build, WIDTH = 32).
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_e;
  logic [1:0]  op_e;
  logic        mthi_e;
  logic        mtlo_e;
  logic        flush_e;
  logic [31:0] src_a_e;
  logic [31:0] src_b_e;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_e (start_e),
    .op_e    (op_e),
    .mthi_e  (mthi_e),
    .mtlo_e  (mtlo_e),
    .flush_e (flush_e),
    .src_a_e (src_a_e),
    .src_b_e (src_b_e),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait (bounded) for done, check timing and results
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int lat;
    int busy_cnt;
    op_e    = op;
    src_a_e = a;
    src_b_e = b;
    start_e = 1'b1;
    tick();
    start_e  = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check({tag, " done pulse width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int done_cnt;
    reset   = 1'b1;
    start_e = 1'b0;
    op_e    = 2'b00;
    mthi_e  = 1'b0;
    mtlo_e  = 1'b0;
    flush_e = 1'b0;
    src_a_e = '0;
    src_b_e = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);

    run_op("multu max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3*7", OpMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("divu 7/0", OpDivu, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div -1/0", OpDiv, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    check("div ovf no X", 64'($isunknown({hi, lo, busy, done})), 64'd0);
    run_op("divu 100/7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("mult min*min", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    run_op("multu 16x", OpMultu, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780);

    // Flush in the middle of a divide: no write, no done
    op_e    = OpDiv;
    src_a_e = 32'd100;
    src_b_e = 32'd7;
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi", 64'(hi), 64'd1);
    check("flush lo", 64'(lo), 64'h2345_6780);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("flush no done", 64'(done_cnt), 64'd0);

    // mthi while busy is ignored; result lands in HI
    op_e    = OpDivu;
    src_a_e = 32'd7;
    src_b_e = 32'd0;
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    src_a_e = 32'h1234;
    mthi_e  = 1'b1;
    lat     = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("mthi busy done seen", 64'(done), 64'd1);
    check("mthi busy hi", 64'(hi), 64'd7);
    mthi_e = 1'b0;
    tick();

    // mthi / mtlo while idle
    src_a_e = 32'h1234;
    mthi_e  = 1'b1;
    tick();
    mthi_e = 1'b0;
    check("mthi idle hi", 64'(hi), 64'h1234);
    check("mthi idle done", 64'(done), 64'd0);
    src_a_e = 32'hABCD;
    mthi_e  = 1'b1;
    mtlo_e  = 1'b1;
    tick();
    mthi_e = 1'b0;
    mtlo_e = 1'b0;
    check("mt both hi", 64'(hi), 64'hABCD);
    check("mt both lo", 64'(lo), 64'hABCD);
    check("mt both done", 64'(done), 64'd0);
    check("mt both busy", 64'(busy), 64'd0);

    // start wins over mthi in the same cycle
    op_e    = OpMultu;
    src_a_e = 32'd2;
    src_b_e = 32'd3;
    mthi_e  = 1'b1;
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    mthi_e  = 1'b0;
    check("start over mthi hi", 64'(hi), 64'hABCD);
    check("start over mthi busy", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("start over mthi result hi", 64'(hi), 64'd0);
    check("start over mthi result lo", 64'(lo), 64'd6);
    tick();

    // flush in idle drops start and mthi
    flush_e = 1'b1;
    start_e = 1'b1;
    mthi_e  = 1'b1;
    src_a_e = 32'h55;
    tick();
    flush_e = 1'b0;
    start_e = 1'b0;
    mthi_e  = 1'b0;
    check("idle flush busy", 64'(busy), 64'd0);
    check("idle flush hi", 64'(hi), 64'd0);
    tick();
    check("idle flush done", 64'(done), 64'd0);

    // reset mid-operation
    op_e    = OpDivu;
    src_a_e = 32'd50;
    src_b_e = 32'd5;
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset mid busy", 64'(busy), 64'd0);
    check("reset mid hi", 64'(hi), 64'd0);
    check("reset mid lo", 64'(lo), 64'd6 - 64'd6);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("reset mid no done", 64'(done_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
